// File: rtl/dsp_result_reporter.sv
// rtl/dsp_result_reporter.sv - warm-up, decimate, buffer and frame DSP48E2 results as a byte stream
// Optional trailing checksum byte per frame: define REPORTER_CHECKSUM_EN.
module dsp_result_reporter #(
    parameter int LATENCY    = 4,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [46:0] p_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int WW = $clog2(LATENCY + 1);
    localparam int DW = $clog2(DECIM + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [WW-1:0] WARM_MAX  = WW'(LATENCY);
    localparam logic [WW-1:0] WARM_LAST = WW'(LATENCY - 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
`ifdef REPORTER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DATA
    } state_t;

    state_t         state;
    logic           en_d;
    logic [WW-1:0]  warm_cnt;
    logic [DW-1:0]  dec_cnt;
    logic [47:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [47:0]    shreg;
    logic [2:0]     byte_idx;
    logic [7:0]     seq;
`ifdef REPORTER_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    logic candidate, keep, empty, full, accept, last_accept, pop, push_ok, drop;

    // Event number warm_cnt+1 is a candidate once it reaches LATENCY.
    assign candidate = en_d && (warm_cnt >= WARM_LAST);
    assign keep      = candidate && (dec_cnt == '0);
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign accept    = tx_valid && tx_ready;
`ifdef REPORTER_CHECKSUM_EN
    assign last_accept = accept && (state == S_CSUM);
`else
    assign last_accept = accept && (state == S_DATA) && (byte_idx == 3'd5);
`endif
    assign pop     = !empty && ((state == S_IDLE) || last_accept);
    assign push_ok = keep && (!full || pop);
    assign drop    = keep && full && !pop;
    assign busy    = (state != S_IDLE) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d     <= 1'b0;
            warm_cnt <= '0;
            dec_cnt  <= '0;
            drop_cnt <= 8'h00;
        end else begin
            en_d <= in_en;
            if (en_d && (warm_cnt != WARM_MAX))
                warm_cnt <= warm_cnt + 1'b1;
            if (candidate)
                dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
            if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {p_in[46], p_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            shreg    <= '0;
            byte_idx <= '0;
            seq      <= 8'h00;
`ifdef REPORTER_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shreg    <= mem[rd_ptr];
                        tx_data  <= 8'hA5;
                        tx_valid <= 1'b1;
                        state    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (accept) begin
                        tx_data <= seq;
`ifdef REPORTER_CHECKSUM_EN
                        csum    <= seq;
`endif
                        state   <= S_SEQ;
                    end
                end
                S_SEQ: begin
                    if (accept) begin
                        tx_data  <= shreg[47:40];
                        shreg    <= {shreg[39:0], 8'h00};
`ifdef REPORTER_CHECKSUM_EN
                        csum     <= csum ^ shreg[47:40];
`endif
                        byte_idx <= 3'd0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (byte_idx != 3'd5) begin
                            tx_data  <= shreg[47:40];
                            shreg    <= {shreg[39:0], 8'h00};
`ifdef REPORTER_CHECKSUM_EN
                            csum     <= csum ^ shreg[47:40];
`endif
                            byte_idx <= byte_idx + 3'd1;
                        end
`ifdef REPORTER_CHECKSUM_EN
                        else begin
                            tx_data <= csum;
                            state   <= S_CSUM;
                        end
`endif
                    end
                end
`ifdef REPORTER_CHECKSUM_EN
                S_CSUM: ;
`endif
                default: state <= S_IDLE;
            endcase

            // Frame end overrides the case: chain straight into the next frame when one is queued.
            if (last_accept) begin
                seq <= seq + 8'd1;
                if (!empty) begin
                    shreg   <= mem[rd_ptr];
                    tx_data <= 8'hA5;
                    state   <= S_SYNC;
                end else begin
                    tx_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_result_reporter.sv
// tb/tb_dsp_result_reporter.sv - scoreboard bench for dsp_result_reporter
module tb_dsp_result_reporter;

`ifdef REPORTER_CHECKSUM_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_en;
    logic        tx_ready;
    logic        sel;
    logic [46:0] p_in;

    logic        in_en_a, in_en_b;
    logic [7:0]  tx_data_a, tx_data_b, drop_a, drop_b;
    logic        tx_valid_a, tx_valid_b, busy_a, busy_b;
    logic [7:0]  mon_data, mon_drop;
    logic        mon_valid, mon_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [47:0] sb_q [$];
    logic [46:0] stim_q [$];
    logic [7:0]  exp_seq [2];

    always #5 clk = ~clk;

    assign in_en_a   = in_en & ~sel;
    assign in_en_b   = in_en & sel;
    assign mon_data  = sel ? tx_data_b  : tx_data_a;
    assign mon_valid = sel ? tx_valid_b : tx_valid_a;
    assign mon_busy  = sel ? busy_b     : busy_a;
    assign mon_drop  = sel ? drop_b     : drop_a;

    dsp_result_reporter #(.LATENCY(4), .DECIM(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_en(in_en_a), .p_in(p_in),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .busy(busy_a), .drop_cnt(drop_a)
    );

    dsp_result_reporter #(.LATENCY(4), .DECIM(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_en(in_en_b), .p_in(p_in),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .busy(busy_b), .drop_cnt(drop_b)
    );

    // Consecutive enable events; p_in for event k is presented in the en_d cycle.
    task automatic drive_burst();
        int n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            in_en = (i < n);
            if (i > 0) p_in = stim_q[i-1];
        end
        stim_q.delete();
    endtask

    task automatic drive_paced(input int gap);
        for (int i = 0; i < stim_q.size(); i++) begin
            @(posedge clk); #1;
            in_en = 1'b1;
            @(posedge clk); #1;
            in_en = 1'b0;
            p_in  = stim_q[i];
            repeat (gap) @(posedge clk);
        end
        stim_q.delete();
    endtask

    task automatic recv_frames(input int nframes, input bit gapless);
        logic [47:0] smp;
        logic [7:0]  exp_b [9];
        int waited;
        for (int f = 0; f < nframes; f++) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL scoreboard_empty: frame %0d has no expected sample", f);
                return;
            end
            smp = sb_q.pop_front();
            exp_b[0] = 8'hA5;
            exp_b[1] = exp_seq[sel];
            for (int k = 0; k < 6; k++) exp_b[2+k] = smp[47-8*k -: 8];
            exp_b[8] = exp_b[1];
            for (int k = 2; k < 8; k++) exp_b[8] = exp_b[8] ^ exp_b[k];
            for (int b = 0; b < FL; b++) begin
                waited = 0;
                @(negedge clk);
                while (!(mon_valid && tx_ready) && waited < 200) begin
                    @(negedge clk);
                    waited++;
                end
                total_cnt++;
                if (waited >= 200) begin
                    $display("FAIL byte_timeout: frame %0d byte %0d got no tx_valid, want one within 200 cycles", f, b);
                    return;
                end
                if (mon_data !== exp_b[b])
                    $display("FAIL frame_byte f%0d b%0d: got %02h want %02h", f, b, mon_data, exp_b[b]);
                else
                    pass_cnt++;
                if (gapless && (f > 0 || b > 0)) begin
                    total_cnt++;
                    if (waited != 0)
                        $display("FAIL back_to_back f%0d b%0d: got gap %0d want 0", f, b, waited);
                    else
                        pass_cnt++;
                end
            end
            exp_seq[sel] = exp_seq[sel] + 8'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_en = 1'b0; tx_ready = 1'b1; sel = 1'b0; p_in = '0;
        exp_seq[0] = 8'h00; exp_seq[1] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt += 5;
        if (tx_valid_a !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid_a); else pass_cnt++;
        if (tx_data_a !== 8'h00) $display("FAIL reset_tx_data: got %02h want 00", tx_data_a); else pass_cnt++;
        if (busy_a !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy_a); else pass_cnt++;
        if (drop_a !== 8'h00)    $display("FAIL reset_drop_cnt: got %0d want 0", drop_a); else pass_cnt++;
        if (tx_valid_b !== 1'b0) $display("FAIL reset_tx_valid_b: got %b want 0", tx_valid_b); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_warmup();
        stim_q = '{47'd1, 47'd2, 47'd3, 47'h102, 47'd7};
        sb_q.push_back(48'h102);
        sb_q.push_back(48'h7);
        fork
            drive_burst();
            recv_frames(2, 1'b0);
        join
        repeat (2) @(negedge clk);
        total_cnt++;
        if (mon_busy !== 1'b0) $display("FAIL warmup_busy_idle: got %b want 0", mon_busy); else pass_cnt++;
    endtask

    task automatic test_negative();
        stim_q = '{ {47{1'b1}} };
        sb_q.push_back(48'hFFFF_FFFF_FFFF);
        fork
            drive_burst();
            recv_frames(1, 1'b0);
        join
    endtask

    task automatic test_decimation();
        sel = 1'b1;
        stim_q = '{47'd0, 47'd0, 47'd0};
        for (int v = 10; v <= 16; v++) stim_q.push_back(47'(v));
        sb_q.push_back(48'd10);
        sb_q.push_back(48'd13);
        sb_q.push_back(48'd16);
        fork
            drive_burst();
            recv_frames(3, 1'b0);
        join
        repeat (20) @(negedge clk);
        total_cnt++;
        if (mon_valid !== 1'b0) $display("FAIL decim_extra_frame: got tx_valid %b want 0", mon_valid); else pass_cnt++;
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk); rst = 1'b1; tx_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        exp_seq[0] = 8'h00;
        sb_q.delete();
        stim_q = '{47'h3C, 47'h3C, 47'h3C};
        for (int v = 0; v < 6; v++) stim_q.push_back(47'(32'h21 + v));
        for (int v = 0; v < 5; v++) sb_q.push_back(48'(32'h21 + v));
        drive_burst();
        repeat (4) @(negedge clk);
        total_cnt += 3;
        if (mon_drop !== 8'd1)   $display("FAIL overflow_drop_cnt: got %0d want 1", mon_drop); else pass_cnt++;
        if (mon_valid !== 1'b1)  $display("FAIL stall_tx_valid: got %b want 1", mon_valid); else pass_cnt++;
        if (mon_data !== 8'hA5)  $display("FAIL stall_tx_data: got %02h want a5", mon_data); else pass_cnt++;
        @(posedge clk); #1;
        tx_ready = 1'b1;
        recv_frames(5, 1'b1);
        @(negedge clk);
        total_cnt += 2;
        if (mon_busy !== 1'b0)  $display("FAIL drain_busy: got %b want 0", mon_busy); else pass_cnt++;
        if (mon_valid !== 1'b0) $display("FAIL drain_tx_valid: got %b want 0", mon_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int seen = 0;
        int waited = 0;
        stim_q = '{47'h77};
        fork
            drive_burst();
            while (seen < 4 && waited < 200) begin
                @(negedge clk);
                if (tx_valid_a) seen++;
                waited++;
            end
        join
        total_cnt++;
        if (seen < 4) $display("FAIL midframe_reach_data: got %0d bytes want 4", seen); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt += 2;
        if (tx_valid_a !== 1'b0) $display("FAIL midframe_tx_valid: got %b want 0", tx_valid_a); else pass_cnt++;
        if (busy_a !== 1'b0)     $display("FAIL midframe_busy: got %b want 0", busy_a); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        sb_q.delete();
        exp_seq[0] = 8'h00;
        stim_q = '{47'h3C, 47'h3C, 47'h3C, 47'h1234};
        sb_q.push_back(48'h1234);
        fork
            drive_burst();
            recv_frames(1, 1'b0);
        join
        repeat (20) @(negedge clk);
        total_cnt++;
        if (tx_valid_a !== 1'b0) $display("FAIL midframe_warmup_leak: got tx_valid %b want 0", tx_valid_a); else pass_cnt++;
    endtask

    task automatic test_seq_wrap();
        logic [46:0] v;
        for (int i = 0; i < 257; i++) begin
            v = {15'($urandom), 32'($urandom)};
            stim_q.push_back(v);
            sb_q.push_back({v[46], v});
        end
        fork
            drive_paced(8);
            recv_frames(257, 1'b0);
        join
        total_cnt++;
        if (drop_a !== 8'd0) $display("FAIL wrap_drop_cnt: got %0d want 0", drop_a); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_negative();
        test_decimation();
        test_backpressure();
        test_reset_mid_frame();
        test_seq_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
